// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full_adder driven LSB-first, carry registered; optional ovf output under SERIAL_ADDER_OVF_EN.
// Latency: out_valid rises WIDTH cycles after the input-accept edge; one operation per WIDTH+2 cycles at best.
// Backpressure: in_ready only in IDLE; result, cout and out_valid hold while out_ready is low.

module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
`ifdef SERIAL_ADDER_OVF_EN
    output logic             ovf,
`endif
    output logic             busy
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] s_sr;
    logic [WIDTH-1:0] s_nxt;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             fa_sum;
    logic             fa_cout;

    full_adder u_fa (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .cin  (carry),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    // The new sum bit enters at the MSB so that after WIDTH shifts bit 0 sits at the LSB.
    always_comb begin
        s_nxt            = s_sr >> 1;
        s_nxt[WIDTH-1]   = fa_sum;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            a_sr      <= '0;
            b_sr      <= '0;
            s_sr      <= '0;
            carry     <= 1'b0;
            cnt       <= '0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        a_sr     <= a;
                        b_sr     <= b;
                        carry    <= cin;
                        cnt      <= '0;
                        state    <= SHIFT;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                SHIFT: begin
                    s_sr  <= s_nxt;
                    carry <= fa_cout;
                    a_sr  <= a_sr >> 1;
                    b_sr  <= b_sr >> 1;
                    cnt   <= cnt + CW'(1);
                    if (cnt == CW'(WIDTH - 1)) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        sum       <= s_nxt;
                        cout      <= fa_cout;
`ifdef SERIAL_ADDER_OVF_EN
                        // On the last edge the carry register holds the carry into the MSB.
                        ovf       <= carry ^ fa_cout;
`endif
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed and random checks of serial_adder_ctrl at WIDTH=8 and WIDTH=1 with a result scoreboard.
module tb_serial_adder_ctrl;
    logic       clk;
    logic       rst_n;

    logic       in_valid8, in_ready8, out_valid8, out_ready8, cin8, cout8, busy8;
    logic [7:0] a8, b8, sum8;
    logic       in_valid1, in_ready1, out_valid1, out_ready1, cin1, cout1, busy1;
    logic [0:0] a1, b1, sum1;
`ifdef SERIAL_ADDER_OVF_EN
    logic       ovf8, ovf1;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    logic [9:0] q8[$];
    logic [1:0] q1[$];

    serial_adder_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .cin(cin8),
        .out_valid(out_valid8), .out_ready(out_ready8),
        .sum(sum8), .cout(cout8),
`ifdef SERIAL_ADDER_OVF_EN
        .ovf(ovf8),
`endif
        .busy(busy8)
    );

    serial_adder_ctrl #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid1), .in_ready(in_ready1),
        .a(a1), .b(b1), .cin(cin1),
        .out_valid(out_valid1), .out_ready(out_ready1),
        .sum(sum1), .cout(cout1),
`ifdef SERIAL_ADDER_OVF_EN
        .ovf(ovf1),
`endif
        .busy(busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Model: plain integer addition plus the sign-based overflow rule.
    task automatic push8(input logic [7:0] a, input logic [7:0] b, input logic c);
        logic [8:0] res;
        logic       ov;
        res = {1'b0, a} + {1'b0, b} + {8'd0, c};
        ov  = (a[7] == b[7]) && (res[7] != a[7]);
        q8.push_back({ov, res});
    endtask

    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic c, input int hold);
        int         lat;
        logic [7:0] s0;
        logic       c0;
        logic [9:0] e;
        a8 = a; b8 = b; cin8 = c; in_valid8 = 1'b1;
        check("in_ready_idle", in_ready8, 1);
        tick();
        push8(a, b, c);
        in_valid8 = 1'b0;
        a8 = ~a; b8 = a ^ b; cin8 = ~c;
        check("shift_in_ready", in_ready8, 0);
        check("shift_busy", busy8, 1);
        lat = 0;
        while (!out_valid8 && lat < 40) begin
            tick();
            lat++;
        end
        check("latency8", lat, 8);
        s0 = sum8; c0 = cout8;
        for (int i = 0; i < hold; i++) begin
            in_valid8 = 1'b1;
            a8 = 8'($urandom);
            tick();
            check("bp_sum", sum8, s0);
            check("bp_cout", cout8, c0);
            check("bp_valid", out_valid8, 1);
            check("bp_in_ready", in_ready8, 0);
        end
        in_valid8 = 1'b0;
        out_ready8 = 1'b1;
        check("sb8_nonempty", q8.size() != 0, 1);
        if (q8.size() != 0) begin
            e = q8.pop_front();
            check("sum8", sum8, e[7:0]);
            check("cout8", cout8, e[8]);
`ifdef SERIAL_ADDER_OVF_EN
            check("ovf8", ovf8, e[9]);
`endif
        end
        tick();
        out_ready8 = 1'b0;
        check("post_valid", out_valid8, 0);
        check("post_in_ready", in_ready8, 1);
        check("post_busy", busy8, 0);
    endtask

    task automatic op1(input logic a, input logic b, input logic c);
        int         lat;
        logic [1:0] e;
        a1 = a; b1 = b; cin1 = c; in_valid1 = 1'b1;
        check("in_ready1", in_ready1, 1);
        tick();
        q1.push_back(2'(a) + 2'(b) + 2'(c));
        in_valid1 = 1'b0;
        a1 = ~a; b1 = ~b; cin1 = ~c;
        lat = 0;
        while (!out_valid1 && lat < 10) begin
            tick();
            lat++;
        end
        check("latency1", lat, 1);
        out_ready1 = 1'b1;
        check("sb1_nonempty", q1.size() != 0, 1);
        if (q1.size() != 0) begin
            e = q1.pop_front();
            check("res1", {cout1, sum1}, e);
        end
        tick();
        out_ready1 = 1'b0;
        check("post_valid1", out_valid1, 0);
    endtask

    initial begin
        rst_n = 1'b1;
        in_valid8 = 0; out_ready8 = 0; a8 = 0; b8 = 0; cin8 = 0;
        in_valid1 = 0; out_ready1 = 0; a1 = 0; b1 = 0; cin1 = 0;
        #2 rst_n = 1'b0;
        #2;
        check("rst_in_ready", in_ready8, 1);
        check("rst_out_valid", out_valid8, 0);
        check("rst_busy", busy8, 0);
        check("rst_sum", sum8, 0);
        check("rst_cout", cout8, 0);
        tick();
        rst_n = 1'b1;
        tick();

        op8(8'h00, 8'h00, 1'b0, 0);
        op8(8'hFF, 8'h01, 1'b0, 0);
        op8(8'h5A, 8'hA5, 1'b1, 0);
        op8(8'h80, 8'h80, 1'b0, 0);
        op8(8'h7F, 8'h01, 1'b0, 5);

        // Abort an operation after three SHIFT cycles; sum still holds 0x80 from above.
        a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1; in_valid8 = 1'b1;
        tick();
        in_valid8 = 1'b0;
        tick(); tick(); tick();
        rst_n = 1'b0;
        #1;
        check("mid_rst_in_ready", in_ready8, 1);
        check("mid_rst_out_valid", out_valid8, 0);
        check("mid_rst_busy", busy8, 0);
        check("mid_rst_sum", sum8, 0);
        check("mid_rst_cout", cout8, 0);
        rst_n = 1'b1;
        tick();
        op8(8'h12, 8'h34, 1'b0, 0);

        for (int i = 0; i < 24; i++)
            op8(8'($urandom), 8'($urandom), 1'($urandom), int'($urandom_range(0, 2)));

        for (int i = 0; i < 8; i++) begin
            logic [2:0] v;
            v = 3'(i);
            op1(v[2], v[1], v[0]);
        end

        check("sb8_drained", q8.size(), 0);
        check("sb1_drained", q1.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
